// File: rtl/uart_tx_framer.sv
// uart_tx_framer: latches a selected byte of the sensor sum and serializes it as a UART frame
module uart_tx_framer #(
  parameter int CLKS_PER_BIT = 87,
  parameter int PARITY_EN    = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tx_send,
  input  logic [1:0]  send_sel,
  input  logic [15:0] sum,
  output logic        tx,
  output logic        tx_busy,
  output logic        tx_done,
  output logic        tx_overrun
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam logic [15:0] LAST      = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  STOP_LAST = 3'(STOP_BITS - 1);
  state_t      state_q;
  logic [15:0] baud_q;
  logic [2:0]  idx_q;
  logic [7:0]  shift_q;
  logic        par_q, tx_q, busy_q, done_q, ovr_q;
  logic [7:0]  byte_sel;
  logic        bit_end, done_next;
  always_comb begin
    byte_sel  = send_sel == 2'd0 ? sum[7:0] : send_sel == 2'd1 ? sum[15:8] : send_sel == 2'd2 ? 8'hA5 : 8'h00;
    bit_end   = baud_q == LAST;
    // done is registered, so it is raised one cycle ahead of the final stop cycle
    done_next = state_q == STOP && idx_q == STOP_LAST && baud_q == LAST - 16'd1;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      ovr_q  <= ovr_q | (tx_send && state_q != IDLE);
      done_q <= done_next;
      baud_q <= (state_q == IDLE || bit_end) ? 16'd0 : baud_q + 16'd1;
      case (state_q)
        IDLE: if (tx_send) begin
          shift_q <= byte_sel;
          par_q   <= ^byte_sel;
          idx_q   <= '0;
          tx_q    <= 1'b0;
          busy_q  <= 1'b1;
          state_q <= START;
        end
        START: if (bit_end) begin
          tx_q    <= shift_q[0];
          state_q <= DATA;
        end
        DATA: if (bit_end) begin
          if (idx_q == 3'd7) begin
            idx_q   <= '0;
            tx_q    <= PARITY_EN != 0 ? par_q : 1'b1;
            state_q <= PARITY_EN != 0 ? PARITY : STOP;
          end else begin
            idx_q <= idx_q + 3'd1;
            tx_q  <= shift_q[idx_q + 3'd1];
          end
        end
        PARITY: if (bit_end) begin
          tx_q    <= 1'b1;
          state_q <= STOP;
        end
        STOP: if (bit_end) begin
          if (idx_q == STOP_LAST) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else idx_q <= idx_q + 3'd1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign tx         = tx_q;
  assign tx_busy    = busy_q;
  assign tx_done    = done_q;
  assign tx_overrun = ovr_q;
endmodule

// File: tb/tb_uart_tx_framer.sv
// tb_uart_tx_framer: directed frame checks on three parameterizations sharing one clock
module tb_uart_tx_framer;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  send = '0;
  logic [1:0]  sel = '0;
  logic [15:0] sum = '0;
  logic        tx_w[3], busy_w[3], done_w[3], ovr_w[3];
  int          passed = 0, total = 0;
  always #5 clk = ~clk;
  uart_tx_framer #(.CLKS_PER_BIT(4), .PARITY_EN(0), .STOP_BITS(1)) u0 (.clk(clk), .reset(reset), .tx_send(send[0]), .send_sel(sel), .sum(sum), .tx(tx_w[0]), .tx_busy(busy_w[0]), .tx_done(done_w[0]), .tx_overrun(ovr_w[0]));
  uart_tx_framer #(.CLKS_PER_BIT(4), .PARITY_EN(1), .STOP_BITS(1)) u1 (.clk(clk), .reset(reset), .tx_send(send[1]), .send_sel(sel), .sum(sum), .tx(tx_w[1]), .tx_busy(busy_w[1]), .tx_done(done_w[1]), .tx_overrun(ovr_w[1]));
  uart_tx_framer #(.CLKS_PER_BIT(4), .PARITY_EN(0), .STOP_BITS(2)) u2 (.clk(clk), .reset(reset), .tx_send(send[2]), .send_sel(sel), .sum(sum), .tx(tx_w[2]), .tx_busy(busy_w[2]), .tx_done(done_w[2]), .tx_overrun(ovr_w[2]));
  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
  endtask
  // bits lists the line level per bit period, first bit in the MSB position of the nb-bit field
  task automatic send_frame(input int w, input logic [1:0] s, input logic [15:0] sm, input logic [11:0] bits, input int nb, input int ovr_at);
    @(negedge clk);
    sel = s;
    sum = sm;
    send[w] = 1'b1;
    @(posedge clk);
    #1;
    send[w] = 1'b0;
    sel = ~s;
    sum = ~sm;
    for (int i = 0; i < nb * 4; i++) begin
      chk($sformatf("d%0d_tx_c%0d", w, i), tx_w[w], bits[nb - 1 - i / 4]);
      chk($sformatf("d%0d_busy_c%0d", w, i), busy_w[w], 1'b1);
      chk($sformatf("d%0d_done_c%0d", w, i), done_w[w], i == nb * 4 - 1);
      send[w] = i == ovr_at;
      @(posedge clk);
      #1;
    end
    send[w] = 1'b0;
    chk($sformatf("d%0d_busy_end", w), busy_w[w], 1'b0);
    chk($sformatf("d%0d_done_end", w), done_w[w], 1'b0);
    chk($sformatf("d%0d_tx_idle", w), tx_w[w], 1'b1);
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_tx", tx_w[k], 1'b1);
      chk("rst_busy", busy_w[k], 1'b0);
      chk("rst_done", done_w[k], 1'b0);
      chk("rst_ovr", ovr_w[k], 1'b0);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    sel = 2'd0;
    sum = 16'h12C3;
    send[0] = 1'b1;
    @(posedge clk);
    #1;
    send[0] = 1'b0;
    repeat (17) @(posedge clk);
    #1;
    chk("mid_busy", busy_w[0], 1'b1);
    chk("mid_tx_d3", tx_w[0], 1'b0);
    reset = 1'b1;
    #1;
    chk("async_rst_tx", tx_w[0], 1'b1);
    chk("async_rst_busy", busy_w[0], 1'b0);
    @(negedge clk);
    reset = 1'b0;
    send_frame(0, 2'd0, 16'h12C3, 12'b0110000111, 10, -1);
    send_frame(0, 2'd1, 16'h12C3, 12'b0010010001, 10, -1);
    send_frame(0, 2'd3, 16'h12C3, 12'b0000000001, 10, -1);
    chk("no_ovr0", ovr_w[0], 1'b0);
    send_frame(1, 2'd0, 16'h0307, 12'b01110000011, 11, -1);
    send_frame(1, 2'd1, 16'h0307, 12'b01100000001, 11, -1);
    chk("no_ovr1", ovr_w[1], 1'b0);
    send_frame(0, 2'd0, 16'h12C3, 12'b0110000111, 10, 20);
    chk("ovr_set", ovr_w[0], 1'b1);
    send_frame(0, 2'd1, 16'h12C3, 12'b0010010001, 10, -1);
    chk("ovr_sticky", ovr_w[0], 1'b1);
    send_frame(1, 2'd0, 16'h0307, 12'b01110000011, 11, 43);
    chk("ovr_stop_edge", ovr_w[1], 1'b1);
    @(posedge clk);
    #1;
    chk("stop_edge_dropped", busy_w[1], 1'b0);
    send_frame(2, 2'd2, 16'h0000, 12'b01010010111, 11, -1);
    send_frame(2, 2'd0, 16'h00C3, 12'b01100001111, 11, -1);
    chk("b2b_no_ovr", ovr_w[2], 1'b0);
    reset = 1'b1;
    #1;
    chk("ovr_cleared", ovr_w[0], 1'b0);
    @(negedge clk);
    reset = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
